// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter: state/owner encodings,
// the latched memory command, and the saturating counter increment.
package dmem_arbiter_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Completed-transaction counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the requester that was
// not served last wins. req_i[0] is the CPU, req_i[1] the debug port.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_i,
  output logic       valid_c_o,
  output owner_e     winner_c_o
);

  always_comb begin
    valid_c_o  = |req_i;
    winner_c_o = OWN_CPU;
    if (req_i == 2'b11) begin
      winner_c_o = (last_i == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (req_i[1]) begin
      winner_c_o = OWN_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU port and a debug port onto a single-port synchronous-read
// memory; one transaction at a time, all outputs registered.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic              write_lock_i,
  output logic              cpu_gnt_o,
  output logic              cpu_done_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              dbg_gnt_o,
  output logic              dbg_done_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_err_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  cpu_count_o,
  output logic [CNT_W-1:0]  dbg_count_o
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic              lock_hit_q, lock_hit_d;
  logic              req_we_q, req_we_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dbg_gnt_q, dbg_gnt_d;
  logic              cpu_done_q, cpu_done_d;
  logic              dbg_done_q, dbg_done_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              dbg_err_q, dbg_err_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cpu_count_q, cpu_count_d;
  logic [CNT_W-1:0]  dbg_count_q, dbg_count_d;

  logic              pick_valid;
  owner_e            pick_winner;
  mem_cmd_t          cpu_cmd, dbg_cmd, win_cmd;
  logic              win_lock_hit;

  rr_pick2 u_pick (
    .req_i      ({dbg_req_i, cpu_req_i}),
    .last_i     (last_q),
    .valid_c_o  (pick_valid),
    .winner_c_o (pick_winner)
  );

  assign cpu_cmd = '{we: cpu_we_i, addr: cpu_addr_i, wdata: cpu_wdata_i};
  assign dbg_cmd = '{we: dbg_we_i, addr: dbg_addr_i, wdata: dbg_wdata_i};
  assign win_cmd = (pick_winner == OWN_DBG) ? dbg_cmd : cpu_cmd;
  // A locked debug write is downgraded to a read whose data is thrown away.
  assign win_lock_hit = (pick_winner == OWN_DBG) && win_cmd.we && write_lock_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_DBG;
      lock_hit_q  <= 1'b0;
      req_we_q    <= 1'b0;
      cpu_gnt_q   <= 1'b0;
      dbg_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      dbg_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      dbg_err_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      cpu_count_q <= '0;
      dbg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      lock_hit_q  <= lock_hit_d;
      req_we_q    <= req_we_d;
      cpu_gnt_q   <= cpu_gnt_d;
      dbg_gnt_q   <= dbg_gnt_d;
      cpu_done_q  <= cpu_done_d;
      dbg_done_q  <= dbg_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      dbg_err_q   <= dbg_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      cpu_count_q <= cpu_count_d;
      dbg_count_q <= dbg_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    lock_hit_d  = lock_hit_q;
    req_we_d    = req_we_q;
    cpu_gnt_d   = cpu_gnt_q;
    dbg_gnt_d   = dbg_gnt_q;
    cpu_done_d  = cpu_done_q;
    dbg_done_d  = dbg_done_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    dbg_err_d   = dbg_err_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_count_d = cpu_count_q;
    dbg_count_d = dbg_count_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_ISSUE;
          owner_d     = pick_winner;
          lock_hit_d  = win_lock_hit;
          req_we_d    = win_cmd.we;
          mem_en_d    = 1'b1;
          mem_we_d    = win_cmd.we & ~win_lock_hit;
          mem_addr_d  = win_cmd.addr;
          mem_wdata_d = win_cmd.wdata;
          if (pick_winner == OWN_DBG) dbg_gnt_d = 1'b1;
          else                        cpu_gnt_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d  = ST_WAIT;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
      ST_WAIT: begin
        // Read data is valid now, one cycle after the enable was sampled.
        state_d   = ST_RESP;
        last_d    = owner_q;
        cpu_gnt_d = 1'b0;
        dbg_gnt_d = 1'b0;
        if (owner_q == OWN_DBG) begin
          dbg_done_d  = 1'b1;
          dbg_err_d   = lock_hit_q;
          dbg_count_d = sat_inc(dbg_count_q);
          if (!req_we_q) dbg_rdata_d = mem_rdata_i;
        end else begin
          cpu_done_d  = 1'b1;
          cpu_count_d = sat_inc(cpu_count_q);
          if (!req_we_q) cpu_rdata_d = mem_rdata_i;
        end
      end
      ST_RESP: begin
        state_d    = ST_IDLE;
        cpu_done_d = 1'b0;
        dbg_done_d = 1'b0;
        dbg_err_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign cpu_gnt_o   = cpu_gnt_q;
  assign dbg_gnt_o   = dbg_gnt_q;
  assign cpu_done_o  = cpu_done_q;
  assign dbg_done_o  = dbg_done_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dbg_rdata_o = dbg_rdata_q;
  assign dbg_err_o   = dbg_err_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;
  assign cpu_count_o = cpu_count_q;
  assign dbg_count_o = dbg_count_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural 32x8 synchronous-read memory, a
// vector table of single transactions, and directed multi-cycle sequences.
module tb_dmem_arbiter;

  logic       clock;
  logic       reset;
  logic       cpu_req, cpu_we, dbg_req, dbg_we, write_lock;
  logic [4:0] cpu_addr, dbg_addr, mem_addr;
  logic [7:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata;
  logic       cpu_gnt, cpu_done, dbg_gnt, dbg_done, dbg_err;
  logic [7:0] cpu_rdata, dbg_rdata, cpu_count, dbg_count;
  logic       mem_en, mem_we, busy;

  logic [7:0] mem [32];

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .dbg_req_i   (dbg_req),
    .dbg_we_i    (dbg_we),
    .dbg_addr_i  (dbg_addr),
    .dbg_wdata_i (dbg_wdata),
    .write_lock_i(write_lock),
    .cpu_gnt_o   (cpu_gnt),
    .cpu_done_o  (cpu_done),
    .cpu_rdata_o (cpu_rdata),
    .dbg_gnt_o   (dbg_gnt),
    .dbg_done_o  (dbg_done),
    .dbg_rdata_o (dbg_rdata),
    .dbg_err_o   (dbg_err),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy),
    .cpu_count_o (cpu_count),
    .dbg_count_o (dbg_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Read-first single-port memory with one cycle of read latency.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    bit         dbg;
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
    bit         lock;
    logic [7:0] exp_rd;
    bit         exp_we;
    bit         exp_err;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    write_lock = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {cpu_gnt, dbg_gnt, cpu_done, dbg_done, dbg_err, mem_en, mem_we, busy,
               mem_addr, mem_wdata, cpu_rdata, dbg_rdata, cpu_count, dbg_count}, 32'h0);
    chk({name, "_lo"}, {24'h0, cpu_count | dbg_count}, 32'h0);
  endtask

  // Issue one transaction and follow it to its done pulse, then drop the request.
  task automatic run_txn(input bit dbg, input bit we, input logic [4:0] a, input logic [7:0] d,
                         input bit lock, output int lat, output int en_at, output bit saw_we,
                         output bit err, output bit gnt1, output bit busy_at_done);
    if (dbg) begin
      dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
    write_lock = lock;
    lat = 0; en_at = 0; saw_we = 0; err = 0; gnt1 = 0; busy_at_done = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (mem_en && en_at == 0) en_at = k;
      if (mem_en && mem_we) saw_we = 1;
      if (k == 1) gnt1 = dbg ? dbg_gnt : cpu_gnt;
      if (dbg ? dbg_done : cpu_done) begin
        lat = k;
        err = dbg_err;
        busy_at_done = busy;
        break;
      end
    end
    if (lat == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL txn_timeout: no done within 20 cycles, expected done at cycle 3");
    end
    cpu_req = 0; dbg_req = 0; write_lock = 0;
    tick();
  endtask

  int         lat, en_at;
  bit         saw_we, err, gnt1, bsy;
  logic [7:0] e_cpu_rd, e_dbg_rd, e_cpu_cnt, e_dbg_cnt;
  int         first;
  bit         got_c, got_d;
  int         ord[8];
  int         n_done;

  initial begin
    vecs[0] = '{0, 1, 5'd5,  8'h3C, 0, 8'h00, 1, 0, 8'd1};
    vecs[1] = '{0, 0, 5'd5,  8'h00, 0, 8'h3C, 0, 0, 8'd2};
    vecs[2] = '{1, 1, 5'd3,  8'h55, 0, 8'h00, 1, 0, 8'd1};
    vecs[3] = '{1, 1, 5'd3,  8'hAA, 1, 8'h00, 0, 1, 8'd2};
    vecs[4] = '{1, 0, 5'd3,  8'h00, 0, 8'h55, 0, 0, 8'd3};
    vecs[5] = '{0, 1, 5'd3,  8'h77, 1, 8'h3C, 1, 0, 8'd3};
    vecs[6] = '{0, 0, 5'd3,  8'h00, 1, 8'h77, 0, 0, 8'd4};
    vecs[7] = '{1, 0, 5'd5,  8'h00, 0, 8'h3C, 0, 0, 8'd4};
    vecs[8] = '{1, 1, 5'd31, 8'hF0, 0, 8'h3C, 1, 0, 8'd5};
    vecs[9] = '{0, 0, 5'd31, 8'h00, 0, 8'hF0, 0, 0, 8'd5};

    clear_inputs();
    reset = 1;
    #2;
    chk_reset_vals("reset_async");
    do_reset();
    chk_reset_vals("reset_release");

    e_cpu_rd = 8'h00; e_dbg_rd = 8'h00; e_cpu_cnt = 8'h00; e_dbg_cnt = 8'h00;
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].dbg, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lock,
              lat, en_at, saw_we, err, gnt1, bsy);
      if (vecs[i].dbg) begin
        e_dbg_rd = vecs[i].exp_rd; e_dbg_cnt = vecs[i].exp_cnt;
      end else begin
        e_cpu_rd = vecs[i].exp_rd; e_cpu_cnt = vecs[i].exp_cnt;
      end
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_en_cycle", i), 32'(en_at), 32'd1);
      chk($sformatf("v%0d_gnt", i), 32'(gnt1), 32'd1);
      chk($sformatf("v%0d_mem_we", i), 32'(saw_we), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_busy", i), 32'(bsy), 32'd1);
      chk($sformatf("v%0d_cpu_rdata", i), 32'(cpu_rdata), 32'(e_cpu_rd));
      chk($sformatf("v%0d_dbg_rdata", i), 32'(dbg_rdata), 32'(e_dbg_rd));
      chk($sformatf("v%0d_cpu_count", i), 32'(cpu_count), 32'(e_cpu_cnt));
      chk($sformatf("v%0d_dbg_count", i), 32'(dbg_count), 32'(e_dbg_cnt));
      chk($sformatf("v%0d_idle_after", i),
          32'({cpu_done, dbg_done, dbg_err, busy, cpu_gnt, dbg_gnt}), 32'd0);
    end

    // Simultaneous first requests after reset: CPU wins the tie.
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd5;
    dbg_req = 1; dbg_we = 0; dbg_addr = 5'd3;
    first = -1; got_c = 0; got_d = 0;
    for (int k = 0; k < 40 && !(got_c && got_d); k++) begin
      tick();
      if (cpu_done) begin
        if (first < 0) first = 0;
        got_c = 1; cpu_req = 0;
      end
      if (dbg_done) begin
        if (first < 0) first = 1;
        got_d = 1; dbg_req = 0;
      end
    end
    cpu_req = 0; dbg_req = 0;
    tick();
    chk("tie_first_cpu", 32'(first), 32'd0);
    chk("tie_both_done", 32'({got_c, got_d}), 32'h3);
    chk("tie_counts", 32'({cpu_count, dbg_count}), 32'h0101);
    chk("tie_rdata", 32'({cpu_rdata, dbg_rdata}), 32'h3C77);

    // Both requesters held continuously: service alternates.
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd5;
    dbg_req = 1; dbg_we = 0; dbg_addr = 5'd31;
    n_done = 0;
    for (int k = 0; k < 100 && n_done < 8; k++) begin
      tick();
      if (cpu_done && n_done < 8) begin ord[n_done] = 0; n_done++; end
      if (dbg_done && n_done < 8) begin ord[n_done] = 1; n_done++; end
      if (n_done == 8) begin cpu_req = 0; dbg_req = 0; end
    end
    cpu_req = 0; dbg_req = 0;
    tick();
    tick();
    chk("alt_n_done", 32'(n_done), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("alt_order_%0d", i), 32'(ord[i]), 32'(i % 2));
    chk("alt_counts", 32'({cpu_count, dbg_count}), 32'h0404);
    chk("alt_idle", 32'(busy), 32'd0);

    // Reset in WAIT abandons the transaction; memory keeps its contents.
    do_reset();
    run_txn(0, 1, 5'd7, 8'h11, 0, lat, en_at, saw_we, err, gnt1, bsy);
    chk("rst_pre_count", 32'(cpu_count), 32'd1);
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd7;
    tick();
    tick();
    chk("rst_in_wait_busy", 32'({busy, cpu_gnt, mem_en}), 32'b110);
    reset = 1;
    #1;
    chk_reset_vals("rst_mid_async");
    cpu_req = 0;
    tick();
    chk("rst_mid_no_done", 32'({cpu_done, cpu_count}), 32'd0);
    reset = 0;
    run_txn(0, 0, 5'd7, 8'h00, 0, lat, en_at, saw_we, err, gnt1, bsy);
    chk("rst_post_latency", 32'(lat), 32'd3);
    chk("rst_post_rdata", 32'(cpu_rdata), 32'h11);
    chk("rst_post_count", 32'(cpu_count), 32'd1);

    // Counter saturation over 300 completions.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      run_txn(0, 0, 5'd5, 8'h00, 0, lat, en_at, saw_we, err, gnt1, bsy);
      if (i == 0)   chk("sat_first", 32'(cpu_count), 32'd1);
      if (i == 253) chk("sat_254", 32'(cpu_count), 32'hFE);
      if (i == 254) chk("sat_255", 32'(cpu_count), 32'hFF);
      if (i == 255) chk("sat_256", 32'(cpu_count), 32'hFF);
    end
    chk("sat_final", 32'(cpu_count), 32'hFF);
    chk("sat_dbg_count", 32'(dbg_count), 32'd0);
    chk("sat_rdata", 32'(cpu_rdata), 32'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
